// File: rtl/slice_in_fifo_pkg.sv
// slice_in_fifo_pkg: shared decoder types and sizing helpers for the per-slice input FIFO.
package slice_in_fifo_pkg;

    localparam int DATA_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        PRELOAD,
        STREAM
    } state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/slice_fifo_mem.sv
// slice_fifo_mem: DEPTH x W register array, one write port and one asynchronous read port.
module slice_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int W     = 257
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/slice_in_fifo.sv
// slice_in_fifo: per-slice first-word fall-through input buffer with initial-delay preload and sticky error flags.
// Define SLICE_IN_FIFO_WATERMARK_EN to build the max_level high-watermark register.
module slice_in_fifo
    import slice_in_fifo_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [11:0]            init_words,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_sof,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    output logic                   sync_err,
    output logic [$clog2(DEPTH):0] max_level
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    state_t          state, state_nx;
    logic [PW-1:0]   wptr, rptr;
    logic            full, empty, accept, push, pop;
    logic [11:0]     thr;
    logic [DATA_W:0] head;

    assign fill_level = wptr - rptr;
    assign full       = fill_level == PW'(DEPTH);
    assign empty      = fill_level == '0;
    assign thr        = (init_words == 12'd0) ? 12'd1 : init_words;

    always_comb begin
        state_nx  = state;
        accept    = (state == IDLE) ? in_sof : 1'b1;
        out_valid = (state == STREAM) & ~empty;
        if (state == IDLE && push) state_nx = PRELOAD;
        if (state == PRELOAD && ((12'(fill_level) >= thr) || full)) state_nx = STREAM;
    end

    // flush outranks any same-cycle write or pop
    assign push = in_valid & ~full & accept & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (in_valid & full) overflow <= 1'b1;
            if (state == IDLE && in_valid && !in_sof) sync_err <= 1'b1;
        end
    end

    slice_fifo_mem #(
        .DEPTH(DEPTH),
        .W    (DATA_W + 1)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wptr[AW-1:0]),
        .wdata({in_sof, in_data}),
        .raddr(rptr[AW-1:0]),
        .rdata(head)
    );

    // storage is never reset, so the head is masked until it holds a valid word
    assign out_data = out_valid ? head[DATA_W-1:0] : '0;
    assign out_sof  = out_valid & head[DATA_W];

`ifdef SLICE_IN_FIFO_WATERMARK_EN
    logic [PW-1:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) max_q <= '0;
        else if (flush) max_q <= '0;
        else if (fill_level > max_q) max_q <= fill_level;
    end

    assign max_level = max_q;
`else
    assign max_level = '0;
`endif

endmodule

// File: doc/slice_in_fifo.md
# slice_in_fifo

Per-slice input buffer in the VDC-M decoder, instantiated once per slice directly downstream of the slice demultiplexer. Each instance captures that slice's realigned 256-bit chunk words and serves them to the slice's entropy decoder over a valid/ready handshake. Output is held back until an initial-delay fill threshold is reached after start of frame. Overflow and sequencing errors are flagged as sticky bits.

## Interface
- DEPTH, 64: FIFO depth in 256-bit words; power of two, at least 4.
- DATA_W, 256: word width in bits.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of the FIFO and state; asserted between frames.
- init_words  in  12  initial-delay threshold in words, static during a frame.
- in_valid  in  1  write strobe, one slice's bit of the demux valid vector.
- in_data  in  DATA_W  write word, byte 0 in bits [7:0].
- in_sof  in  1  slice-start tag; high on the first valid word of a frame for this slice.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_W  head word.
- out_sof  out  1  slice-start tag of the head word.
- fill_level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- sync_err  out  1  sticky: a write arrived in IDLE without in_sof.
- max_level  out  $clog2(DEPTH)+1  high watermark; present only with the configuration macro.

## Operation
- Storage: DEPTH entries of DATA_W+1 bits (data plus sof tag). Write and read pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. fill_level = wptr - rptr. full when fill_level == DEPTH; empty when fill_level == 0.
- push = in_valid & ~full & state accepts writes. pop = out_valid & out_ready.
- Writes are refused when full, even if a pop happens in the same cycle; a refused write sets overflow. A pop while empty cannot occur because out_valid is low.
- States:
  - IDLE: out_valid = 0. A write with in_sof = 1 is stored and moves the state to PRELOAD. A write with in_sof = 0 is dropped and sets sync_err.
  - PRELOAD: every write is stored and out_valid = 0. Move to STREAM when fill_level >= max(init_words, 1) or when full. An init_words value greater than DEPTH therefore exits only on full.
  - STREAM: every write is stored and out_valid = ~empty. The block stays in STREAM until flush or reset.
- in_sof = 1 arriving in PRELOAD or STREAM is stored as a tag only and causes no state change.
- flush: pointers go to 0, the state goes to IDLE, and overflow and sync_err clear. flush takes priority over a write or pop in the same cycle; that write is discarded and sets no flag.
- Reset values: out_valid 0, out_sof 0, fill_level 0, overflow 0, sync_err 0, max_level 0, state IDLE. out_data resets to 0; storage is not reset.

## Timing
- The FIFO is first-word fall-through. A word written in cycle N is visible at the output in cycle N+1, provided the state is STREAM in N+1.
- The PRELOAD to STREAM transition is evaluated on the registered fill_level. out_valid rises in the cycle after the threshold is met.
- out_data and out_sof come from the head entry and are held stable while out_valid & ~out_ready.
- A push and a pop in the same cycle leave fill_level unchanged.
- Flags and fill_level update one cycle after the causing event.

## Configuration
- SLICE_IN_FIFO_WATERMARK_EN defined: max_level is a register that tracks the maximum fill_level since the last flush or reset. It is used for rate-buffer sizing during bring-up.
- SLICE_IN_FIFO_WATERMARK_EN undefined: max_level is tied to 0 and the register is not built.

## Structure
- Shared decoder package:
  - DATA_W default.
  - State enum: IDLE, PRELOAD, STREAM.
  - Pointer-width function clog2(DEPTH)+1.
- One sub-module, slice_fifo_mem: a DEPTH x (DATA_W+1) register array with one write port and one asynchronous read port. The FSM, pointers and flags live in slice_in_fifo.

## Test plan
- Preload: init_words=8, 8 writes at 1 per cycle starting with in_sof=1, out_ready=1. Expected: out_valid stays 0 until the cycle after fill_level reaches 8; words then drain in order; out_sof=1 on the first word only.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1. Expected: out_data and out_sof stay stable and fill_level is unchanged with no writes.
- Overflow: DEPTH=64, init_words=100, 65 writes with no pops. Expected: STREAM entered on full; the 65th write is dropped; overflow=1; fill_level=64; with the macro defined, max_level=64.
- Simultaneous push/pop: at fill_level=10 in STREAM, push and pop every cycle for 20 cycles. Expected: fill_level stays at 10 and the data order is preserved.
- Sync error: after flush, a write with in_sof=0. Expected: sync_err=1, fill_level=0, state IDLE. A following write with in_sof=1 is accepted.
- Flush mid-stream: flush during STREAM in the same cycle as a write. Expected: the next cycle shows fill_level=0, out_valid=0, and flags clear. Async rst_n asserted mid-frame gives the same result, with all outputs at their reset values.
